// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store
// path (m0) and the boot/DMA loader (m1). Each access runs IDLE -> ISSUE ->
// WAIT (MEM_LAT-1 cycles) -> RESP.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   mX_req/we/addr/wdata  requester X command, held until mX_gnt
//   mX_gnt                one-cycle grant, coincident with mem_en
//   mX_rvalid/rdata       one-cycle completion; rdata is 0 for writes
//   mem_en/we/addr/wdata  memory command, driven only in the grant cycle
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//   busy                  high whenever the arbiter is not IDLE
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (m0 always
// wins). Default build is round-robin.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              sel_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Command of the currently selected requester
  assign sel_req   = sel_q ? m1_req   : m0_req;
  assign sel_we    = sel_q ? m1_we    : m0_we;
  assign sel_addr  = sel_q ? m1_addr  : m0_addr;
  assign sel_wdata = sel_q ? m1_wdata : m0_wdata;

  assign busy = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
    we_d      = we_q;
    lat_d     = lat_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;

    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          sel_d   = prio_q;
          state_d = ISSUE;
        end else if (m0_req) begin
          sel_d   = 1'b0;
          state_d = ISSUE;
        end else if (m1_req) begin
          sel_d   = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // A request dropped in this cycle counts as withdrawn
        if (sel_req) begin
          mem_en    = 1'b1;
          mem_we    = sel_we;
          mem_addr  = sel_addr;
          mem_wdata = sel_wdata;
          m0_gnt    = ~sel_q;
          m1_gnt    = sel_q;
          we_d      = sel_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          prio_d    = ~sel_q;
`endif
          if (MEM_LAT > 1) begin
            lat_d   = LAT_W'(MEM_LAT - 1);
            state_d = WAIT;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = RESP;
        end
      end

      RESP: begin
        // Read data arrives on mem_rdata in this cycle; writes return zero
        if (sel_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = we_q ? '0 : mem_rdata;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = we_q ? '0 : mem_rdata;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4), each with
// a synchronous-read memory model, a transaction-timeline reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  logic        rq [2][2];
  logic        wq [2][2];
  logic [31:0] aq [2][2];
  logic [31:0] dq [2][2];
  logic        gnt[2][2];
  logic        rv [2][2];
  logic [31:0] rd [2][2];
  logic        men[2];
  logic        mwe[2];
  logic [31:0] madr[2];
  logic [31:0] mwd[2];
  logic [31:0] mrd[2];
  logic        bsy[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .m0_req(rq[0][0]), .m0_we(wq[0][0]), .m0_addr(aq[0][0]), .m0_wdata(dq[0][0]),
    .m0_gnt(gnt[0][0]), .m0_rvalid(rv[0][0]), .m0_rdata(rd[0][0]),
    .m1_req(rq[0][1]), .m1_we(wq[0][1]), .m1_addr(aq[0][1]), .m1_wdata(dq[0][1]),
    .m1_gnt(gnt[0][1]), .m1_rvalid(rv[0][1]), .m1_rdata(rd[0][1]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(madr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0]), .busy(bsy[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .reset(rst_n),
    .m0_req(rq[1][0]), .m0_we(wq[1][0]), .m0_addr(aq[1][0]), .m0_wdata(dq[1][0]),
    .m0_gnt(gnt[1][0]), .m0_rvalid(rv[1][0]), .m0_rdata(rd[1][0]),
    .m1_req(rq[1][1]), .m1_we(wq[1][1]), .m1_addr(aq[1][1]), .m1_wdata(dq[1][1]),
    .m1_gnt(gnt[1][1]), .m1_rvalid(rv[1][1]), .m1_rdata(rd[1][1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(madr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1]), .busy(bsy[1])
  );

  // ---------------- memory model ----------------
  logic [31:0] marr[2][256];
  bit          wr_v[2][256];
  logic [31:0] pipe[2][16];

  function automatic logic [31:0] dflt(input int k, input logic [7:0] a);
    if (a == 8'h10) return 32'hDEAD_BEEF;
    return {16'hC0DE, 4'(k), 4'h0, a};
  endfunction

  function automatic logic [31:0] mem_rd(input int k, input logic [7:0] a);
    return wr_v[k][a] ? marr[k][a] : dflt(k, a);
  endfunction

  // Read data is presented for exactly one cycle, MEM_LAT cycles after mem_en
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 15; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      if (men[k] && !mwe[k]) pipe[k][0] <= mem_rd(k, madr[k][7:0]);
      else                   pipe[k][0] <= 32'h5A5A_5A5A;
      if (men[k] && mwe[k]) begin
        marr[k][madr[k][7:0]] <= mwd[k];
        wr_v[k][madr[k][7:0]] <= 1'b1;
      end
    end
  end
  assign mrd[0] = pipe[0][0];
  assign mrd[1] = pipe[1][3];

  // ---------------- reference model + monitor state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          avail[2], issue_at[2], rv_at[2], isel[2], rv_s[2];
  bit          prio[2];
  logic [31:0] rv_d[2];

  int          g_cyc[2][2], r_cyc[2][2], g_cnt[2][2], r_cnt[2][2];
  logic [31:0] r_dat[2][2];
  logic        g_we[2];
  logic [31:0] g_adr[2], g_wd[2];
  int          busy_cnt[2], wait_cnt[2];
  int          gord[$];

  // Timeline model: an idle cycle samples requests, the next cycle is the
  // grant cycle, completion follows MEM_LAT cycles later, then idle again.
  task automatic check_cycle(input int k);
    int          s;
    int          lat;
    logic        e_g0, e_g1, e_r0, e_r1, e_en, e_we, e_busy;
    logic [31:0] e_rd0, e_rd1, e_a, e_d;
    logic [134:0] ev, av;
    lat = (k == 0) ? 1 : 4;
    e_g0 = 0; e_g1 = 0; e_r0 = 0; e_r1 = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_rd0 = '0; e_rd1 = '0; e_a = '0; e_d = '0;
    if (!rst_n) begin
      avail[k] = cyc + 1; issue_at[k] = -1; rv_at[k] = -1; prio[k] = 1'b0;
    end else begin
      e_busy = (cyc < avail[k]);
      if (cyc == issue_at[k]) begin
        s = isel[k];
        if (rq[k][s]) begin
          e_en = 1'b1; e_we = wq[k][s]; e_a = aq[k][s]; e_d = dq[k][s];
          if (s == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
          rv_at[k] = cyc + lat;
          rv_s[k]  = s;
          rv_d[k]  = wq[k][s] ? 32'h0 : mem_rd(k, aq[k][s][7:0]);
          avail[k] = cyc + lat + 1;
          if (!FIXED) prio[k] = (s == 0);
        end
      end
      if (cyc == rv_at[k]) begin
        if (rv_s[k] == 0) begin e_r0 = 1'b1; e_rd0 = rv_d[k]; end
        else              begin e_r1 = 1'b1; e_rd1 = rv_d[k]; end
      end
      if (cyc >= avail[k]) begin
        if (rq[k][0] || rq[k][1]) begin
          isel[k]     = (rq[k][0] && rq[k][1]) ? int'(prio[k]) : (rq[k][1] ? 1 : 0);
          issue_at[k] = cyc + 1;
          avail[k]    = cyc + 2;
        end else begin
          avail[k] = cyc + 1;
        end
      end
    end
    ev = {e_g0, e_g1, e_r0, e_r1, e_en, e_busy, e_rd0, e_rd1, e_we, e_a, e_d};
    av = {gnt[k][0], gnt[k][1], rv[k][0], rv[k][1], men[k], bsy[k], rd[k][0], rd[k][1],
          e_en ? mwe[k] : 1'b0, e_en ? madr[k] : 32'h0, e_en ? mwd[k] : 32'h0};
    n_cmp++;
    if (av !== ev) begin
      n_fail++;
      $display("FAIL model_cycle inst=%0d cyc=%0d actual=%h required=%h", k, cyc, av, ev);
    end
    // Event log for the directed scenarios
    for (int m = 0; m < 2; m++) begin
      if (gnt[k][m] === 1'b1) begin
        g_cyc[k][m] = cyc; g_cnt[k][m]++;
        g_we[k] = mwe[k]; g_adr[k] = madr[k]; g_wd[k] = mwd[k];
        if (k == 0) gord.push_back(m);
      end
      if (rv[k][m] === 1'b1) begin
        r_cyc[k][m] = cyc; r_cnt[k][m]++; r_dat[k][m] = rd[k][m];
      end
    end
    if (bsy[k] === 1'b1) begin
      busy_cnt[k]++;
      if (!gnt[k][0] && !gnt[k][1] && !rv[k][0] && !rv[k][1]) wait_cnt[k]++;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_cycle(k);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int k, input int m, input bit want_rv, input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if ((want_rv ? rv[k][m] : gnt[k][m]) === 1'b1) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting for %s inst=%0d m=%0d", nm, want_rv ? "rvalid" : "gnt", k, m);
  endtask

  task automatic txn(input int k, input int m, input logic we, input logic [31:0] a,
                     input logic [31:0] d, output int t0);
    tick();
    rq[k][m] = 1'b1; wq[k][m] = we; aq[k][m] = a; dq[k][m] = d;
    t0 = cyc;
    wait_sig(k, m, 1'b0, "txn_gnt");
    tick();
    rq[k][m] = 1'b0;
    wait_sig(k, m, 1'b1, "txn_rvalid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, bc, wc, winner;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++) begin
        rq[k][m] = 1'b0; wq[k][m] = 1'b0; aq[k][m] = '0; dq[k][m] = '0;
      end
    fork
      model_loop();
    join_none

    // Reset state
    repeat (3) tick();
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_mem_en", 32'(men[0]), 32'd0);
    chk("reset_rvalid", 32'(rv[1][0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single CPU read, MEM_LAT=1
    txn(0, 0, 1'b0, 32'h10, 32'h0, t0);
    chk("rd_gnt_cycle", 32'(g_cyc[0][0] - t0), 32'd1);
    chk("rd_rvalid_cycle", 32'(r_cyc[0][0] - t0), 32'd2);
    chk("rd_data", r_dat[0][0], 32'hDEAD_BEEF);
    chk("rd_mem_addr", g_adr[0], 32'h10);
    chk("rd_mem_we", 32'(g_we[0]), 32'd0);
    chk("rd_m1_quiet", 32'(g_cnt[0][1] + r_cnt[0][1]), 32'd0);

    // Loader write, then CPU reads it back
    txn(0, 1, 1'b1, 32'h40, 32'h0000_000A, t0);
    chk("wr_mem_we", 32'(g_we[0]), 32'd1);
    chk("wr_mem_addr", g_adr[0], 32'h40);
    chk("wr_mem_wdata", g_wd[0], 32'h0000_000A);
    chk("wr_rvalid_delay", 32'(r_cyc[0][1] - g_cyc[0][1]), 32'd1);
    chk("wr_rdata_zero", r_dat[0][1], 32'h0);
    txn(0, 0, 1'b0, 32'h40, 32'h0, t0);
    chk("readback_data", r_dat[0][0], 32'h0000_000A);

    // Withdrawal: last grant went to m0, so m1 is favoured next
    bc = busy_cnt[0];
    tick();
    rq[0][1] = 1'b1; wq[0][1] = 1'b0; aq[0][1] = 32'h30;
    tick();
    rq[0][1] = 1'b0;
    repeat (3) tick();
    chk("withdraw_no_gnt", 32'(g_cnt[0][1]), 32'd1);
    chk("withdraw_busy_cycles", 32'(busy_cnt[0] - bc), 32'd1);
    tick();
    rq[0][0] = 1'b1; aq[0][0] = 32'h10; wq[0][0] = 1'b0;
    rq[0][1] = 1'b1; aq[0][1] = 32'h44; wq[0][1] = 1'b0;
    winner = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (gnt[0][0] === 1'b1) begin winner = 0; break; end
      if (gnt[0][1] === 1'b1) begin winner = 1; break; end
    end
    tick();
    rq[0][0] = 1'b0; rq[0][1] = 1'b0;
    chk("withdraw_next_winner", 32'(winner), FIXED ? 32'd0 : 32'd1);
    repeat (4) tick();

    // Contention from reset: 8 back-to-back grants
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    gord.delete();
    rq[0][0] = 1'b1; wq[0][0] = 1'b0; aq[0][0] = 32'h50;
    rq[0][1] = 1'b1; wq[0][1] = 1'b1; aq[0][1] = 32'h60; dq[0][1] = 32'h1234;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (gord.size() >= 8) break;
    end
    tick();
    rq[0][0] = 1'b0; rq[0][1] = 1'b0;
    repeat (4) tick();
    chk("contend_count", 32'(gord.size()), 32'd8);
    for (int i = 0; i < 8 && i < gord.size(); i++)
      chk($sformatf("contend_order_%0d", i), 32'(gord[i]), FIXED ? 32'd0 : 32'(i % 2));

    // Latency, MEM_LAT=4: busy spans ISSUE, three WAIT cycles and RESP
    bc = busy_cnt[1];
    wc = wait_cnt[1];
    txn(1, 0, 1'b0, 32'h20, 32'h0, t0);
    repeat (2) tick();
    chk("lat4_gnt_cycle", 32'(g_cyc[1][0] - t0), 32'd1);
    chk("lat4_rvalid_cycle", 32'(r_cyc[1][0] - t0), 32'd5);
    chk("lat4_busy_cycles", 32'(busy_cnt[1] - bc), 32'd5);
    chk("lat4_wait_cycles", 32'(wait_cnt[1] - wc), 32'd3);
    chk("lat4_data", r_dat[1][0], 32'hC0DE_1020);

    // Reset in the middle of a MEM_LAT=4 read
    tick();
    rq[1][0] = 1'b1; wq[1][0] = 1'b0; aq[1][0] = 32'h24;
    wait_sig(1, 0, 1'b0, "rst_gnt");
    tick();
    rq[1][0] = 1'b0;
    chk("pre_reset_busy", 32'(bsy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bsy[1]), 32'd0);
    chk("async_rst_rvalid", 32'(rv[1][0]), 32'd0);
    chk("async_rst_mem_en", 32'(men[1]), 32'd0);
    chk("async_rst_mem_addr", madr[1], 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("abandon_no_rvalid", 32'(r_cnt[1][0]), 32'd1);
    txn(1, 0, 1'b0, 32'h24, 32'h0, t0);
    chk("post_rst_data", r_dat[1][0], 32'hC0DE_1024);
    chk("post_rst_rvalid_cycle", 32'(r_cyc[1][0] - t0), 32'd5);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
